// File: rtl/redis_cache_reg_top.sv
// Redis cache host register block: DAT/KEY/CTR decode and busy/start handshake.
// Presents register state to the cache controller and absorbs its results.
package if_types_pkg;

    localparam int AddressBits = 4;

    typedef struct packed {
        logic [63:0] dat;
        logic [31:0] key;
        logic [2:0]  operation;
    } reg_read_t;

    typedef struct packed {
        logic        data_valid;
        logic [63:0] dat;
        logic        busy_valid;
        logic        busy;
        logic        operation_valid;
        logic [2:0]  operation;
    } reg_write_t;

endpackage

module redis_cache_reg_top
    import if_types_pkg::*;
#(
    parameter int AddrW = AddressBits
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             error_o,
    output reg_read_t        reg_read_o,
    output logic             start_o,
    input  reg_write_t       reg_write_i
);

    typedef enum logic [1:0] {
        REG_DAT_LO = 2'd0,
        REG_DAT_HI = 2'd1,
        REG_KEY    = 2'd2,
        REG_CTR    = 2'd3
    } reg_sel_e;

    logic [63:0] dat_q;
    logic [31:0] key_q;
    logic [2:0]  op_q;
    logic        busy_q;

    logic        rvalid_q;
    logic        error_q;
    logic [31:0] rdata_q;
    logic        start_q;

    logic [31:0] addr_ext;
    reg_sel_e    sel;
    logic        align_err;
    logic        range_err;
    logic        lock_err;
    logic        dec_err;
    logic        rd_acc;
    logic        wr_acc;
    logic        wr_dat_lo;
    logic        wr_dat_hi;
    logic        wr_key;
    logic        wr_ctr;
    logic        launch;
    logic [31:0] rd_mux;

    assign addr_ext = 32'(addr_i);
    assign sel      = reg_sel_e'(addr_i[3:2]);

    // Busy lockout uses the pre-update busy, so a same-cycle
    // controller completion still rejects the host write.
    always_comb begin
        align_err = 1'b0;
        range_err = 1'b0;
        lock_err  = 1'b0;
        align_err = (addr_i[1:0] != 2'b00);
        range_err = (addr_ext > 32'hC);
        lock_err  = we_i && busy_q;
        dec_err   = align_err || range_err || lock_err;
    end

    always_comb begin
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        wr_dat_lo = 1'b0;
        wr_dat_hi = 1'b0;
        wr_key    = 1'b0;
        wr_ctr    = 1'b0;
        rd_acc    = req_i && !dec_err && !we_i;
        wr_acc    = req_i && !dec_err && we_i;
        unique case (sel)
            REG_DAT_LO: wr_dat_lo = wr_acc;
            REG_DAT_HI: wr_dat_hi = wr_acc;
            REG_KEY:    wr_key    = wr_acc;
            REG_CTR:    wr_ctr    = wr_acc;
            default:    wr_ctr    = 1'b0;
        endcase
        launch = wr_ctr && (wdata_i[3:1] != 3'b000);
    end

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            REG_DAT_LO: rd_mux = dat_q[31:0];
            REG_DAT_HI: rd_mux = dat_q[63:32];
            REG_KEY:    rd_mux = key_q;
            REG_CTR:    rd_mux = {28'b0, op_q, busy_q};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            start_q  <= 1'b0;
        end else begin
            rvalid_q <= req_i;
            error_q  <= req_i && dec_err;
            rdata_q  <= rd_acc ? rd_mux : 32'h0;
            start_q  <= launch;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q <= '0;
        end else if (reg_write_i.data_valid) begin
            dat_q <= reg_write_i.dat;
        end else if (wr_dat_lo) begin
            dat_q[31:0] <= wdata_i;
        end else if (wr_dat_hi) begin
            dat_q[63:32] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= '0;
        end else if (wr_key) begin
            key_q <= wdata_i;
        end
    end

    // A CTR write with a zero operation clears it without launching.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            if (reg_write_i.operation_valid) begin
                op_q <= reg_write_i.operation;
            end else if (wr_ctr) begin
                op_q <= wdata_i[3:1];
            end
            if (reg_write_i.busy_valid) begin
                busy_q <= reg_write_i.busy;
            end else if (launch) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign rvalid_o             = rvalid_q;
    assign error_o              = error_q;
    assign rdata_o              = rdata_q;
    assign start_o              = start_q;
    assign reg_read_o.dat       = dat_q;
    assign reg_read_o.key       = key_q;
    assign reg_read_o.operation = op_q;

endmodule

// File: tb/tb_redis_cache_reg_top.sv
// Self-checking bench for redis_cache_reg_top.
// Bus responses are checked against a scoreboard of expected results.
module tb_redis_cache_reg_top;
    import if_types_pkg::*;

    localparam int AW = 5;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic          clk;
    logic          rst_ni;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          error;
    reg_read_t     rr;
    logic          start;
    reg_write_t    rw;

    int   errors;
    int   checks;
    int   cyc;
    exp_t sb[$];

    redis_cache_reg_top #(.AddrW(AW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .error_o    (error),
        .reg_read_o (rr),
        .start_o    (start),
        .reg_write_i(rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each expected response is tagged with the cycle it must appear in.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (rvalid !== 1'b1 || error !== e.err || rdata !== e.data) begin
                errors++;
                $display("FAIL %s: rvalid=%b err=%b rdata=%h, want rvalid=1 err=%b rdata=%h",
                         e.name, rvalid, error, rdata, e.err, e.data);
            end
        end else if (rst_ni && rvalid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rvalid: rvalid=%b, want 0", rvalid);
        end
    end

    task automatic access(input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic e_err,
                          input logic [31:0] e_data, input string nm);
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        e.due  = cyc + 1;
        e.err  = e_err;
        e.data = e_data;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        checks++;
        if (rvalid !== 1'b0 || error !== 1'b0 || start !== 1'b0 ||
            rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b err=%b st=%b rd=%h, want 0",
                     rvalid, error, start, rdata);
        end
        checks++;
        if (rr.dat !== 64'h0 || rr.key !== 32'h0 || rr.operation !== 3'h0) begin
            errors++;
            $display("FAIL reset_regs: dat=%h key=%h op=%h, want 0",
                     rr.dat, rr.key, rr.operation);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        access(1'b0, 5'h0, 32'h0, 1'b0, 32'h0, "rst_rd_0");
        access(1'b0, 5'h4, 32'h0, 1'b0, 32'h0, "rst_rd_4");
        access(1'b0, 5'h8, 32'h0, 1'b0, 32'h0, "rst_rd_8");
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h0, "rst_rd_c");
        idle(2);
    endtask

    task automatic test_dat_key();
        access(1'b1, 5'h0, 32'hDEADBEEF, 1'b0, 32'h0, "wr_dat_lo");
        access(1'b1, 5'h4, 32'h01234567, 1'b0, 32'h0, "wr_dat_hi");
        access(1'b1, 5'h8, 32'hCAFEF00D, 1'b0, 32'h0, "wr_key");
        access(1'b0, 5'h0, 32'h0, 1'b0, 32'hDEADBEEF, "rd_dat_lo");
        access(1'b0, 5'h4, 32'h0, 1'b0, 32'h01234567, "rd_dat_hi");
        access(1'b0, 5'h8, 32'h0, 1'b0, 32'hCAFEF00D, "rd_key");
        idle(2);
        checks++;
        if (rr.dat !== 64'h01234567DEADBEEF || rr.key !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reg_read_dat_key: dat=%h key=%h, want 01234567deadbeef cafef00d",
                     rr.dat, rr.key);
        end
    endtask

    task automatic test_ctr_zero();
        access(1'b1, 5'hC, 32'h00000001, 1'b0, 32'h0, "wr_ctr_zero");
        idle(1);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL ctr_zero_start: start=%b, want 0", start);
        end
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h0, "rd_ctr_zero");
        idle(2);
    endtask

    task automatic test_launch();
        access(1'b1, 5'hC, 32'h00000005, 1'b0, 32'h0, "wr_ctr_launch");
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h5, "rd_ctr_busy");
        checks++;
        if (start !== 1'b1 || rr.operation !== 3'd2) begin
            errors++;
            $display("FAIL launch_start: start=%b op=%0d, want 1 2", start, rr.operation);
        end
        idle(1);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL launch_pulse_width: start=%b, want 0", start);
        end
        idle(1);
    endtask

    task automatic test_busy_lockout();
        access(1'b1, 5'h0, 32'hFFFFFFFF, 1'b1, 32'h0, "busy_wr_dat");
        access(1'b0, 5'h0, 32'h0, 1'b0, 32'hDEADBEEF, "busy_rd_dat");
        access(1'b1, 5'hC, 32'h0000000E, 1'b1, 32'h0, "busy_wr_ctr");
        idle(2);
        checks++;
        if (rr.dat !== 64'h01234567DEADBEEF || rr.operation !== 3'd2 || start !== 1'b0) begin
            errors++;
            $display("FAIL busy_unchanged: dat=%h op=%0d st=%b, want 01234567deadbeef 2 0",
                     rr.dat, rr.operation, start);
        end
    endtask

    task automatic test_completion();
        access(1'b1, 5'h8, 32'h11111111, 1'b1, 32'h0, "done_same_cycle_wr");
        rw.data_valid      = 1'b1;
        rw.dat             = 64'hAAAA5555AAAA5555;
        rw.busy_valid      = 1'b1;
        rw.busy            = 1'b0;
        rw.operation_valid = 1'b1;
        rw.operation       = 3'd0;
        access(1'b1, 5'h8, 32'h12345678, 1'b0, 32'h0, "done_next_wr");
        rw = '0;
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h0, "done_rd_ctr");
        access(1'b0, 5'h4, 32'h0, 1'b0, 32'hAAAA5555, "done_rd_hi");
        access(1'b0, 5'h0, 32'h0, 1'b0, 32'hAAAA5555, "done_rd_lo");
        access(1'b0, 5'h8, 32'h0, 1'b0, 32'h12345678, "done_rd_key");
        idle(2);
        checks++;
        if (rr.dat !== 64'hAAAA5555AAAA5555 || rr.key !== 32'h12345678 ||
            rr.operation !== 3'd0) begin
            errors++;
            $display("FAIL done_regs: dat=%h key=%h op=%0d, want aaaa5555aaaa5555 12345678 0",
                     rr.dat, rr.key, rr.operation);
        end
    endtask

    task automatic test_decode_errors();
        access(1'b0, 5'h02, 32'h0, 1'b1, 32'h0, "err_rd_unaligned");
        access(1'b0, 5'h10, 32'h0, 1'b1, 32'h0, "err_rd_range");
        access(1'b1, 5'h0D, 32'h0000000F, 1'b1, 32'h0, "err_wr_unaligned");
        access(1'b1, 5'h14, 32'h0BADBEEF, 1'b1, 32'h0, "err_wr_range");
        access(1'b0, 5'h8, 32'h0, 1'b0, 32'h12345678, "err_key_kept");
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h0, "err_ctr_kept");
        idle(2);
        checks++;
        if (start !== 1'b0 || rr.dat !== 64'hAAAA5555AAAA5555) begin
            errors++;
            $display("FAIL err_no_change: st=%b dat=%h, want 0 aaaa5555aaaa5555",
                     start, rr.dat);
        end
    endtask

    task automatic test_mid_reset();
        access(1'b1, 5'hC, 32'h00000007, 1'b0, 32'h0, "mid_rst_launch");
        @(posedge clk);
        #2;
        sb.delete();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (start !== 1'b0 || rvalid !== 1'b0 || rr.operation !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: st=%b rv=%b op=%0d, want 0 0 0",
                     start, rvalid, rr.operation);
        end
        idle(2);
        rst_ni = 1'b1;
        access(1'b0, 5'hC, 32'h0, 1'b0, 32'h0, "mid_rst_rd_ctr");
        access(1'b0, 5'h0, 32'h0, 1'b0, 32'h0, "mid_rst_rd_dat");
        idle(3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        rw     = '0;
        test_reset();
        test_dat_key();
        test_ctr_zero();
        test_launch();
        test_busy_lockout();
        test_completion();
        test_decode_errors();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: left=%0d, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
